// File: rtl/mem_scan_reader_if.sv
// Bundled control, memory read port and output stream of mem_scan_reader.
// Carries out_class only when ZCNT_CLASS_EN is defined.
interface mem_scan_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7,
  parameter int ZC_W   = 6
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ZC_W-1:0]   out_zcnt;
`ifdef ZCNT_CLASS_EN
  logic [1:0]        out_class;
`endif

  modport slave (
    input  start, base_addr, len, mem_rd_data, out_ready,
    output busy, done, mem_rd_en, mem_rd_addr, out_valid, out_data, out_zcnt
`ifdef ZCNT_CLASS_EN
    , output out_class
`endif
  );

  modport master (
    output start, base_addr, len, mem_rd_data, out_ready,
    input  busy, done, mem_rd_en, mem_rd_addr, out_valid, out_data, out_zcnt
`ifdef ZCNT_CLASS_EN
    , input out_class
`endif
  );
endinterface

// File: rtl/mem_scan_reader.sv
// Streams len words from the scratch memory starting at base_addr, tagging each with its zero count.
// Optional ZCNT_CLASS_EN adds a 2-bit zero-count class per word.
module mem_scan_reader #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int ZC_W   = 6
) (
  input logic              CLK,
  input logic              RSTX,
  mem_scan_reader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              rd_en_q, rd_en_d;
  logic              cap_q;

  logic [DATA_W-1:0] buf_data_q [2];
  logic [ZC_W-1:0]   buf_zc_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        cnt_q;

  logic              push, pop, issue_ok;
  logic [2:0]        occ_after;
  logic [ZC_W-1:0]   cap_zc;

  always_comb begin
    cap_zc = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (!bus.mem_rd_data[i]) cap_zc = cap_zc + ZC_W'(1);
    end
  end

  // Credits: buffered words plus reads still in the memory pipeline never exceed two.
  assign push      = cap_q;
  assign pop       = (cnt_q != 2'd0) && bus.out_ready;
  assign occ_after = 3'(cnt_q) + 3'(push) - 3'(pop);
  assign issue_ok  = (occ_after + 3'(rd_en_q)) < 3'd2;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          ptr_d   = bus.base_addr;
          rem_d   = bus.len;
          state_d = (bus.len == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (rem_q != '0 && issue_ok) begin
          rd_en_d   = 1'b1;
          rd_addr_d = ptr_q;
          ptr_d     = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + ADDR_W'(1);
          rem_d     = rem_q - (ADDR_W + 1)'(1);
          if (rem_q == (ADDR_W + 1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!rd_en_q && !cap_q && occ_after == 3'd0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      cap_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      cap_q     <= rd_en_q;
    end
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      for (int unsigned i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_zc_q[i]   <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        buf_data_q[wr_ptr_q] <= bus.mem_rd_data;
        buf_zc_q[wr_ptr_q]   <= cap_zc;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

`ifdef ZCNT_CLASS_EN
  logic [1:0] buf_cls_q [2];
  logic [1:0] cap_cls;

  always_comb begin
    cap_cls = 2'd2;
    if (cap_zc == ZC_W'(0))      cap_cls = 2'd0;
    else if (cap_zc == ZC_W'(1)) cap_cls = 2'd1;
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      for (int unsigned i = 0; i < 2; i++) buf_cls_q[i] <= '0;
    end else if (push) begin
      buf_cls_q[wr_ptr_q] <= cap_cls;
    end
  end

  assign bus.out_class = buf_cls_q[rd_ptr_q];
`endif

  assign bus.busy        = (state_q == READ) || (state_q == DRAIN);
  assign bus.done        = (state_q == DONE);
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_rd_addr = rd_addr_q;
  assign bus.out_valid   = (cnt_q != 2'd0);
  assign bus.out_data    = buf_data_q[rd_ptr_q];
  assign bus.out_zcnt    = buf_zc_q[rd_ptr_q];
endmodule

// File: tb/tb_mem_scan_reader.sv
// Randomized scans of mem_scan_reader against a word-level reference model of the scan.
module tb_mem_scan_reader;
  localparam int DEPTH = 128;

  logic CLK  = 1'b0;
  logic RSTX = 1'b0;

  mem_scan_reader_if #(.DATA_W(32), .ADDR_W(7), .ZC_W(6)) bus ();
  mem_scan_reader #(.DATA_W(32), .DEPTH(128), .ADDR_W(7), .ZC_W(6)) dut (
    .CLK (CLK),
    .RSTX(RSTX),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [DEPTH];
  always @(posedge CLK) bus.mem_rd_data <= bus.mem_rd_en ? mem[bus.mem_rd_addr] : $urandom;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [31:0] d;
    logic [5:0]  z;
  } exp_t;

  exp_t        exp_q[$];
  bit          scan_active = 0, done_now = 0;
  int          m_len = 0, m_issued = 0, m_hs = 0;
  logic [6:0]  m_base = '0;
  int          done_count = 0, en_count = 0;
  int          acc_cyc = 0, first_valid_cyc = -1, last_hs_cyc = 0, done_cyc = 0;
  logic [31:0] rec_d[$];
  logic [5:0]  rec_z[$];
  logic [6:0]  rec_a[$];
  logic [1:0]  rec_c[$];
  bit          prev_stall = 0;
  logic [31:0] prev_data = '0;

  function automatic logic [1:0] zclass(input logic [5:0] z);
    return (z == 6'd0) ? 2'd0 : (z == 6'd1) ? 2'd1 : 2'd2;
  endfunction

  always @(negedge CLK) begin
    cyc++;
    if (!RSTX) begin
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_rd_en", 32'(bus.mem_rd_en), 0);
      chk("rst_rd_addr", 32'(bus.mem_rd_addr), 0);
      chk("rst_valid", 32'(bus.out_valid), 0);
      chk("rst_data", bus.out_data, 0);
      chk("rst_zcnt", 32'(bus.out_zcnt), 0);
`ifdef ZCNT_CLASS_EN
      chk("rst_class", 32'(bus.out_class), 0);
`endif
      scan_active = 0;
      done_now    = 0;
      exp_q.delete();
      m_issued    = 0;
      m_hs        = 0;
      prev_stall  = 0;
    end else begin
      bit prev_done;
      chk("busy", 32'(bus.busy), 32'(scan_active));
      chk("done", 32'(bus.done), 32'(done_now));
      if (bus.done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (bus.mem_rd_en) begin
        en_count++;
        chk("rd_in_scan", 32'(scan_active && m_issued < m_len), 1);
        chk("rd_addr", 32'(bus.mem_rd_addr), 32'((int'(m_base) + m_issued) % DEPTH));
        rec_a.push_back(bus.mem_rd_addr);
        m_issued++;
      end
      chk("outstanding_le2", 32'((m_issued - m_hs) <= 2), 1);
      if (bus.out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (prev_stall) chk("hold_data", bus.out_data, prev_data);
        if (exp_q.size() == 0) begin
          chk("valid_expected", 32'(bus.out_valid), 0);
        end else begin
          chk("out_data", bus.out_data, exp_q[0].d);
          chk("out_zcnt", 32'(bus.out_zcnt), 32'(exp_q[0].z));
`ifdef ZCNT_CLASS_EN
          chk("out_class", 32'(bus.out_class), 32'(zclass(exp_q[0].z)));
          if (bus.out_ready) rec_c.push_back(bus.out_class);
`endif
          if (bus.out_ready) begin
            rec_d.push_back(bus.out_data);
            rec_z.push_back(bus.out_zcnt);
            void'(exp_q.pop_front());
            m_hs++;
            last_hs_cyc = cyc;
          end
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;

      prev_done = done_now;
      done_now  = 0;
      if (scan_active && m_hs == m_len) begin
        scan_active = 0;
        done_now    = 1;
      end else if (!scan_active && !prev_done && bus.start) begin
        acc_cyc         = cyc;
        m_base          = bus.base_addr;
        m_len           = int'(bus.len);
        m_issued        = 0;
        m_hs            = 0;
        first_valid_cyc = -1;
        rec_d.delete(); rec_z.delete(); rec_a.delete(); rec_c.delete();
        for (int k = 0; k < m_len; k++) begin
          exp_t e;
          e.d = mem[(int'(m_base) + k) % DEPTH];
          e.z = 6'(32 - $countones(e.d));
          exp_q.push_back(e);
        end
        if (m_len == 0) done_now = 1;
        else            scan_active = 1;
      end
    end
  end

  int ready_mode = 0;
  initial begin
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int pidx = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: begin
          bus.out_ready = pat[pidx % 4];
          pidx++;
        end
      endcase
    end
  end

  task automatic run_scan(input logic [6:0] base, input int len, input int glitch_at);
    int dc0 = done_count;
    int limit = 8 * len + 60;
    @(posedge CLK); #1;
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.len       = 8'(len);
    @(posedge CLK); #1;
    bus.start     = 1'b0;
    bus.base_addr = 7'($urandom);
    bus.len       = 8'($urandom_range(0, 128));
    for (int i = 0; i < limit; i++) begin
      if (done_count != dc0) break;
      bus.start = (i == glitch_at);
      @(posedge CLK); #1;
    end
    bus.start = 1'b0;
    if (done_count == dc0) chk("scan_timeout", 32'(done_count), 32'(dc0 + 1));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int en0, dc0;
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0;
    for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;

    repeat (3) @(posedge CLK);
    #1 RSTX = 1'b1;
    en0 = en_count;
    repeat (10) @(posedge CLK);
    #1 chk("idle_no_rd", 32'(en_count), 32'(en0));

    mem[4] = 32'hFFFF_FFFF; mem[5] = 32'h0; mem[6] = 32'hFFFF_0000; mem[7] = 32'h7FFF_FFFF;
    run_scan(7'd4, 4, -1);
    chk("basic_count", 32'(rec_z.size()), 4);
    chk("basic_z0", 32'(rec_z[0]), 0);
    chk("basic_z1", 32'(rec_z[1]), 32);
    chk("basic_z2", 32'(rec_z[2]), 16);
    chk("basic_z3", 32'(rec_z[3]), 1);
    chk("basic_first_valid_lat", 32'(first_valid_cyc - acc_cyc), 4);
    chk("basic_done_lat", 32'(done_cyc - last_hs_cyc), 1);

    run_scan(7'd126, 4, -1);
    chk("wrap_a0", 32'(rec_a[0]), 126);
    chk("wrap_a1", 32'(rec_a[1]), 127);
    chk("wrap_a2", 32'(rec_a[2]), 0);
    chk("wrap_a3", 32'(rec_a[3]), 1);
    chk("wrap_d2", rec_d[2], mem[0]);

    ready_mode = 2;
    run_scan(7'd10, 8, -1);
    chk("bp_count", 32'(rec_d.size()), 8);

    ready_mode = 0;
    en0 = en_count;
    run_scan(7'd0, 0, -1);
    chk("len0_no_rd", 32'(en_count), 32'(en0));
    chk("len0_done_lat", 32'(done_cyc - acc_cyc), 1);

    ready_mode = 1;
    run_scan(7'd20, 6, 2);
    chk("glitch_count", 32'(rec_d.size()), 6);

    ready_mode = 0;
    @(posedge CLK); #1;
    bus.start = 1'b1; bus.base_addr = 7'd30; bus.len = 8'd16;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 200 && m_hs < 5; i++) begin
      @(posedge CLK); #1;
    end
    chk("rst_scan_progress", 32'(m_hs >= 5), 1);
    dc0 = done_count;
    #1 RSTX = 1'b0;
    #1;
    chk("rst_imm_valid", 32'(bus.out_valid), 0);
    chk("rst_imm_data", bus.out_data, 0);
    chk("rst_imm_busy", 32'(bus.busy), 0);
    repeat (3) @(posedge CLK);
    #1 RSTX = 1'b1;
    repeat (5) @(posedge CLK);
    #1 chk("rst_no_done", 32'(done_count), 32'(dc0));
    run_scan(7'd50, 5, -1);
    chk("post_rst_count", 32'(rec_d.size()), 5);

`ifdef ZCNT_CLASS_EN
    mem[60] = 32'h0; mem[61] = 32'hFFFF_FFFF; mem[62] = 32'hFFFF_FFFE;
    run_scan(7'd60, 3, -1);
    chk("class0", 32'(rec_c[0]), 2);
    chk("class1", 32'(rec_c[1]), 0);
    chk("class2", 32'(rec_c[2]), 1);
`endif

    for (int s = 0; s < 40; s++) begin
      int len;
      int glitch;
      for (int a = 0; a < DEPTH; a++) begin
        case ($urandom_range(0, 7))
          0:       mem[a] = 32'h0;
          1:       mem[a] = 32'hFFFF_FFFF;
          2:       mem[a] = 32'hFFFF_FFFE;
          default: mem[a] = $urandom;
        endcase
      end
      len        = (s == 5) ? 128 : (s == 9) ? 0 : $urandom_range(1, 24);
      ready_mode = $urandom_range(0, 2);
      glitch     = (len >= 4 && $urandom_range(0, 1) == 1) ? 2 : -1;
      run_scan(7'($urandom), len, glitch);
      chk("rand_count", 32'(rec_d.size()), 32'(len));
    end

    repeat (3) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
